// File: rtl/sampler_pkg.sv
// Shared types and helpers for the candidate sampler: FSM state encoding,
// Galois LFSR tap masks, the LFSR step function and the chunk count.
package sampler_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GEN   = 3'd1,
    CHECK = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4,
    FAIL  = 3'd5
  } state_t;

  // Right-shift Galois masks for maximal-length polynomials.
  // 16: x^16+x^14+x^13+x^11+1, 32: x^32+x^22+x^2+x+1, 64: x^64+x^63+x^61+x^60+1
  function automatic logic [63:0] lfsr_taps(input int w);
    logic [63:0] t;
    case (w)
      16:      t = 64'h0000_0000_0000_B400;
      32:      t = 64'h0000_0000_8020_0003;
      64:      t = 64'hD800_0000_0000_0000;
      default: t = 64'h0;
    endcase
    return t;
  endfunction

  // One Galois step on a zero-extended w-bit state; result stays within w bits.
  function automatic logic [63:0] lfsr_next(input logic [63:0] q, input int w);
    logic [63:0] t;
    t = lfsr_taps(w);
    return q[0] ? ((q >> 1) ^ t) : (q >> 1);
  endfunction

  // LFSR words needed to fill one candidate.
  function automatic int nch(input int vec_w, input int lfsr_w);
    return (vec_w + lfsr_w - 1) / lfsr_w;
  endfunction

endpackage

// File: rtl/sampler_lfsr.sv
// Galois LFSR with seed load. A zero seed would lock the register up, so it
// is replaced by SEED_RST on load.
module sampler_lfsr
  import sampler_pkg::*;
#(
  parameter int          W        = 32,
  parameter logic [W-1:0] SEED_RST = W'(1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         step_i,
  input  logic         load_i,
  input  logic [W-1:0] seed_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q, q_d;

  // Next state: load wins over step (the controller never asks for both).
  always_comb begin
    q_d = q_q;
    if (load_i)      q_d = (seed_i == '0) ? SEED_RST : seed_i;
    else if (step_i) q_d = W'(lfsr_next(64'(q_q), W));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) q_q <= SEED_RST;
    else     q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/cand_sampler.sv
// Random-search candidate generator for a combinational constraint checker.
// Builds each candidate from NCH LFSR steps, presents it for one cycle, and
// streams satisfying vectors out on a valid/ready port until NUM_SOL are
// delivered or MAX_TRIES rejections have accumulated.
// Optional: define CAND_SAMPLER_DEDUP_EN to reject a satisfying candidate that
// equals the most recently emitted solution of the current run.
module cand_sampler
  import sampler_pkg::*;
#(
  parameter int               VEC_W     = 128,
  parameter int               LFSR_W    = 32,
  parameter int               MAX_TRIES = 1024,
  parameter int               NUM_SOL   = 1,
  parameter logic [LFSR_W-1:0] SEED_RST = LFSR_W'(1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start_i,
  input  logic                           seed_we_i,
  input  logic [LFSR_W-1:0]              seed_i,
  output logic [VEC_W-1:0]               cand_o,
  output logic                           cand_vld_o,
  input  logic                           sat_i,
  output logic                           sol_vld_o,
  input  logic                           sol_rdy_i,
  output logic [VEC_W-1:0]               sol_o,
  output logic                           busy_o,
  output logic                           done_o,
  output logic                           fail_o,
  output logic [$clog2(MAX_TRIES+1)-1:0] tries_o
);

  localparam int NCH = nch(VEC_W, LFSR_W);
  localparam int TW  = $clog2(MAX_TRIES + 1);
  localparam int SW  = $clog2(NUM_SOL + 1);
  localparam int GW  = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [TW-1:0] MAX_T  = TW'(MAX_TRIES);
  localparam logic [SW-1:0] NUM_S  = SW'(NUM_SOL);
  localparam logic [GW-1:0] GEN_LAST = GW'(NCH - 1);

  state_t              state_q, state_d;
  logic [GW-1:0]       gen_cnt_q, gen_cnt_d;
  logic [VEC_W-1:0]    cand_q, cand_d;
  logic [VEC_W-1:0]    sol_q, sol_d;
  logic [TW-1:0]       tries_q, tries_d;
  logic [SW-1:0]       sol_cnt_q, sol_cnt_d;
  logic                cand_vld_q, cand_vld_d;
  logic                sol_vld_q, sol_vld_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                fail_q, fail_d;

  logic                idle_like;
  logic                lfsr_step, lfsr_load;
  logic [LFSR_W-1:0]   lfsr_q, lfsr_nxt;
  logic [VEC_W-1:0]    shift_in;
  logic                dup;
  logic [TW-1:0]       tries_inc;
  logic [SW-1:0]       sol_cnt_inc;

  sampler_lfsr #(
    .W        (LFSR_W),
    .SEED_RST (SEED_RST)
  ) u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .step_i (lfsr_step),
    .load_i (lfsr_load),
    .seed_i (seed_i),
    .q_o    (lfsr_q)
  );

  // The value the LFSR takes on this step is the one shifted into the candidate.
  assign lfsr_nxt = LFSR_W'(lfsr_next(64'(lfsr_q), LFSR_W));

  // New word enters from the MSB side; the oldest bits fall off the bottom.
  if (VEC_W > LFSR_W) begin : g_wide
    assign shift_in = {lfsr_nxt, cand_q[VEC_W-1:LFSR_W]};
  end else begin : g_narrow
    assign shift_in = lfsr_nxt[LFSR_W-1 -: VEC_W];
  end

`ifdef CAND_SAMPLER_DEDUP_EN
  logic seen_q, seen_d;

  assign dup = seen_q && (cand_q == sol_q);

  // sol_q only counts as a previous solution once this run has captured one.
  always_comb begin
    seen_d = seen_q;
    if (idle_like && start_i)                  seen_d = 1'b0;
    else if (state_q == CHECK && sat_i && !dup) seen_d = 1'b1;
  end

  // Previous-solution valid flag.
  always_ff @(posedge clk) begin
    if (rst) seen_q <= 1'b0;
    else     seen_q <= seen_d;
  end
`else
  assign dup = 1'b0;
`endif

  assign idle_like   = (state_q == IDLE) || (state_q == DONE) || (state_q == FAIL);
  assign tries_inc   = tries_q + TW'(1);
  assign sol_cnt_inc = sol_cnt_q + SW'(1);

  // Controller next-state and datapath updates; outputs decoded from next state.
  always_comb begin
    state_d   = state_q;
    gen_cnt_d = gen_cnt_q;
    cand_d    = cand_q;
    sol_d     = sol_q;
    tries_d   = tries_q;
    sol_cnt_d = sol_cnt_q;
    lfsr_step = 1'b0;
    lfsr_load = 1'b0;

    case (state_q)
      IDLE, DONE, FAIL: begin
        lfsr_load = seed_we_i;
        if (start_i) begin
          state_d   = GEN;
          gen_cnt_d = '0;
          tries_d   = '0;
          sol_cnt_d = '0;
        end
      end
      GEN: begin
        lfsr_step = 1'b1;
        cand_d    = shift_in;
        if (gen_cnt_q == GEN_LAST) begin
          state_d   = CHECK;
          gen_cnt_d = '0;
        end else begin
          gen_cnt_d = gen_cnt_q + GW'(1);
        end
      end
      CHECK: begin
        if (sat_i && !dup) begin
          state_d = HOLD;
          sol_d   = cand_q;
        end else begin
          tries_d = tries_inc;
          state_d = (tries_inc == MAX_T) ? FAIL : GEN;
        end
      end
      HOLD: begin
        if (sol_rdy_i) begin
          sol_cnt_d = sol_cnt_inc;
          state_d   = (sol_cnt_inc == NUM_S) ? DONE : GEN;
        end
      end
      default: state_d = IDLE;
    endcase

    cand_vld_d = (state_d == CHECK);
    sol_vld_d  = (state_d == HOLD);
    busy_d     = (state_d == GEN) || (state_d == CHECK) || (state_d == HOLD);
    done_d     = (state_d == DONE);
    fail_d     = (state_d == FAIL);
  end

  // Controller and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      gen_cnt_q  <= '0;
      cand_q     <= '0;
      sol_q      <= '0;
      tries_q    <= '0;
      sol_cnt_q  <= '0;
      cand_vld_q <= 1'b0;
      sol_vld_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      gen_cnt_q  <= gen_cnt_d;
      cand_q     <= cand_d;
      sol_q      <= sol_d;
      tries_q    <= tries_d;
      sol_cnt_q  <= sol_cnt_d;
      cand_vld_q <= cand_vld_d;
      sol_vld_q  <= sol_vld_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      fail_q     <= fail_d;
    end
  end

  assign cand_o     = cand_q;
  assign cand_vld_o = cand_vld_q;
  assign sol_o      = sol_q;
  assign sol_vld_o  = sol_vld_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign fail_o     = fail_q;
  assign tries_o    = tries_q;

endmodule

// File: tb/tb_cand_sampler.sv
// Directed bench for cand_sampler. Three instances share the clock:
//  a: 128/32, NUM_SOL=2, MAX_TRIES=4  (accept-all, reject-all, reset cases)
//  b: 128/32, NUM_SOL=1               (nibble checker, backpressure)
//  c: 1/16,  NUM_SOL=4, MAX_TRIES=16  (1-bit candidates repeat often: dedup)
module tb_cand_sampler;

  localparam int NCH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // golden LFSR steps (right-shift Galois)
  function automatic logic [31:0] m32(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction
  function automatic logic [15:0] m16(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  task automatic m_cand(inout logic [31:0] st, output logic [127:0] c);
    c = '0;
    for (int i = 0; i < NCH; i++) begin
      st = m32(st);
      c  = {st, c[127:32]};
    end
  endtask

  task automatic m_run(inout logic [31:0] st, output logic [127:0] sol, output int tr);
    logic [127:0] c;
    logic hit;
    tr = 0; sol = '0; hit = 1'b0;
    for (int i = 0; i < 1024 && !hit; i++) begin
      m_cand(st, c);
      if (c[3:0] == 4'hA) begin sol = c; hit = 1'b1; end
      else tr++;
    end
  endtask

  // ---- instance a
  logic rst_a, start_a, seed_we_a, sat_a, rdy_a;
  logic [31:0] seed_a;
  logic [127:0] cand_a, sol_a;
  logic cand_vld_a, sol_vld_a, busy_a, done_a, fail_a;
  logic [2:0] tries_a;

  cand_sampler #(.VEC_W(128), .LFSR_W(32), .MAX_TRIES(4), .NUM_SOL(2), .SEED_RST(32'h1)) u_a (
    .clk(clk), .rst(rst_a), .start_i(start_a), .seed_we_i(seed_we_a), .seed_i(seed_a),
    .cand_o(cand_a), .cand_vld_o(cand_vld_a), .sat_i(sat_a), .sol_vld_o(sol_vld_a),
    .sol_rdy_i(rdy_a), .sol_o(sol_a), .busy_o(busy_a), .done_o(done_a), .fail_o(fail_a),
    .tries_o(tries_a));

  // ---- instance b
  logic rst_b, start_b, seed_we_b, sat_b, rdy_b;
  logic [31:0] seed_b;
  logic [127:0] cand_b, sol_b;
  logic cand_vld_b, sol_vld_b, busy_b, done_b, fail_b;
  logic [10:0] tries_b;

  assign sat_b = (cand_b[3:0] == 4'hA);

  cand_sampler #(.VEC_W(128), .LFSR_W(32), .MAX_TRIES(1024), .NUM_SOL(1), .SEED_RST(32'h1)) u_b (
    .clk(clk), .rst(rst_b), .start_i(start_b), .seed_we_i(seed_we_b), .seed_i(seed_b),
    .cand_o(cand_b), .cand_vld_o(cand_vld_b), .sat_i(sat_b), .sol_vld_o(sol_vld_b),
    .sol_rdy_i(rdy_b), .sol_o(sol_b), .busy_o(busy_b), .done_o(done_b), .fail_o(fail_b),
    .tries_o(tries_b));

  // ---- instance c
  logic rst_c, start_c, seed_we_c, sat_c, rdy_c;
  logic [15:0] seed_c;
  logic [0:0] cand_c, sol_c;
  logic cand_vld_c, sol_vld_c, busy_c, done_c, fail_c;
  logic [4:0] tries_c;

  cand_sampler #(.VEC_W(1), .LFSR_W(16), .MAX_TRIES(16), .NUM_SOL(4), .SEED_RST(16'h1)) u_c (
    .clk(clk), .rst(rst_c), .start_i(start_c), .seed_we_i(seed_we_c), .seed_i(seed_c),
    .cand_o(cand_c), .cand_vld_o(cand_vld_c), .sat_i(sat_c), .sol_vld_o(sol_vld_c),
    .sol_rdy_i(rdy_c), .sol_o(sol_c), .busy_o(busy_c), .done_o(done_c), .fail_o(fail_c),
    .tries_o(tries_c));

  // start a run on a; t_end = edges after the start edge until done/fail
  task automatic run_a(input logic we, input logic [31:0] sd, output int t_end, output int ns,
                       output logic [127:0] s0, output logic [127:0] s1, output int tv);
    t_end = -1; ns = 0; s0 = '0; s1 = '0; tv = -1;
    seed_we_a = we; seed_a = sd; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0; seed_we_a = 1'b0;
    for (int k = 1; k <= 60 && t_end < 0; k++) begin
      @(negedge clk);
      if (cand_vld_a && tv < 0) tv = k;
      if (sol_vld_a) begin
        if (ns == 0) s0 = sol_a;
        else if (ns == 1) s1 = sol_a;
        ns++;
      end
      if (done_a || fail_a) t_end = k;
    end
  endtask

  task automatic run_b(input logic we, input logic [31:0] sd, output logic [127:0] s);
    logic got;
    s = '0; got = 1'b0;
    seed_we_b = we; seed_b = sd; start_b = 1'b1; rdy_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0; seed_we_b = 1'b0;
    for (int k = 0; k < 8000 && !done_b && !fail_b; k++) begin
      if (sol_vld_b && !got) begin s = sol_b; got = 1'b1; end
      @(negedge clk);
    end
    chk("b_done", {127'b0, done_b}, 128'd1);
  endtask

  logic [31:0]  st;
  logic [127:0] e0, e1, g0, g1;
  int           t_end, ns, tv, tr;
  logic [15:0]  st16;
  logic         c_seen, c_last, c_bit, m_fail;
  logic [3:0]   m_em, g_em;
  int           m_t, m_s, g_n;

  initial begin
    rst_a = 1; rst_b = 1; rst_c = 1;
    start_a = 0; seed_we_a = 0; seed_a = '0; sat_a = 0; rdy_a = 0;
    start_b = 0; seed_we_b = 0; seed_b = '0; rdy_b = 0;
    start_c = 0; seed_we_c = 0; seed_c = '0; sat_c = 0; rdy_c = 0;
    repeat (2) @(negedge clk);

    // reset state
    chk("rst_cand", cand_a, '0);
    chk("rst_sol", sol_a, '0);
    chk("rst_flags", {123'b0, cand_vld_a, sol_vld_a, busy_a, done_a, fail_a}, '0);
    chk("rst_tries", {125'b0, tries_a}, '0);
    rst_a = 0; rst_b = 0; rst_c = 0;
    @(negedge clk);

    // accept-all, two solutions: done 2*(NCH+2) edges after the start edge
    sat_a = 1; rdy_a = 1;
    st = 32'h1234_5678;
    m_cand(st, e0); m_cand(st, e1);
    run_a(1'b1, 32'h1234_5678, t_end, ns, g0, g1, tv);
    chk("t1_tdone", 128'(t_end), 128'(2 * (NCH + 2)));
    chk("t1_tcheck", 128'(tv), 128'(NCH));
    chk("t1_nsol", 128'(ns), 128'd2);
    chk("t1_sol0", g0, e0);
    chk("t1_sol1", g1, e1);
    chk("t1_tries", {125'b0, tries_a}, '0);
    chk("t1_flags", {125'b0, busy_a, done_a, fail_a}, 128'b010);

    // reject-all, MAX_TRIES=4: fail after 4*(NCH+1) edges, LFSR continues
    sat_a = 0;
    for (int i = 0; i < 4; i++) m_cand(st, e0);
    run_a(1'b0, 32'h0, t_end, ns, g0, g1, tv);
    chk("t2_tfail", 128'(t_end), 128'(4 * (NCH + 1)));
    chk("t2_nsol", 128'(ns), '0);
    chk("t2_tries", {125'b0, tries_a}, 128'd4);
    chk("t2_flags", {125'b0, busy_a, done_a, fail_a}, 128'b001);
    chk("t2_cand", cand_a, e0);

    // reset in GEN
    sat_a = 1; rdy_a = 1; start_a = 1;
    @(negedge clk); start_a = 0;
    chk("t5_busy", {127'b0, busy_a}, 128'd1);
    @(negedge clk);
    rst_a = 1;
    @(negedge clk);
    chk("t5g_cand", cand_a, '0);
    chk("t5g_flags", {123'b0, cand_vld_a, sol_vld_a, busy_a, done_a, fail_a}, '0);
    chk("t5g_tries", {125'b0, tries_a}, '0);
    rst_a = 0;

    // reset in HOLD
    rdy_a = 0; start_a = 1;
    @(negedge clk); start_a = 0;
    for (int k = 0; k < 20 && !sol_vld_a; k++) @(negedge clk);
    chk("t5h_vld", {127'b0, sol_vld_a}, 128'd1);
    rst_a = 1;
    @(negedge clk);
    chk("t5h_vld0", {127'b0, sol_vld_a}, '0);
    chk("t5h_sol", sol_a, '0);
    chk("t5h_busy", {127'b0, busy_a}, '0);
    rst_a = 0; rdy_a = 1;

    // restart after reset: LFSR back at SEED_RST
    st = 32'h1;
    m_cand(st, e0); m_cand(st, e1);
    run_a(1'b0, 32'h0, t_end, ns, g0, g1, tv);
    chk("t5r_tdone", 128'(t_end), 128'(2 * (NCH + 2)));
    chk("t5r_sol0", g0, e0);
    chk("t5r_sol1", g1, e1);

    // nibble checker, seed ACE1, then the same seed again
    st = 32'h0000_ACE1;
    m_run(st, e0, tr);
    run_b(1'b1, 32'h0000_ACE1, g0);
    chk("t3_nib", 128'(g0[3:0]), 128'hA);
    chk("t3_sol", g0, e0);
    chk("t3_tries", {117'b0, tries_b}, 128'(tr));
    run_b(1'b1, 32'h0000_ACE1, g1);
    chk("t3_rerun", g1, e0);
    chk("t3_rtries", {117'b0, tries_b}, 128'(tr));

    // backpressure: held solution, no LFSR movement while stalled
    st = 32'h0000_BEEF;
    m_run(st, e0, tr);
    rdy_b = 0; seed_b = 32'h0000_BEEF; seed_we_b = 1; start_b = 1;
    @(negedge clk); start_b = 0; seed_we_b = 0;
    for (int k = 0; k < 8000 && !sol_vld_b && !fail_b; k++) @(negedge clk);
    chk("t4_sol", sol_b, e0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("t4_vld", {127'b0, sol_vld_b}, 128'd1);
      chk("t4_stable", sol_b, e0);
      chk("t4_cand", cand_b, e0);
    end
    rdy_b = 1;
    @(negedge clk);
    chk("t4_done", {126'b0, sol_vld_b, done_b}, 128'b01);
    chk("t4_tries", {117'b0, tries_b}, 128'(tr));
    m_run(st, e1, tr);
    run_b(1'b0, 32'h0, g1);
    chk("t4_next", g1, e1);
    chk("t4_ntries", {117'b0, tries_b}, 128'(tr));

    // 1-bit candidates, accept-all
    st16 = 16'hACE1; c_seen = 0; c_last = 0; m_fail = 0; m_t = 0; m_s = 0; m_em = '0;
    while (m_s < 4 && !m_fail) begin
      st16  = m16(st16);
      c_bit = st16[15];
`ifdef CAND_SAMPLER_DEDUP_EN
      if (c_seen && c_bit == c_last) begin
        m_t++;
        if (m_t == 16) m_fail = 1;
        continue;
      end
`endif
      m_em[m_s] = c_bit; m_s++; c_last = c_bit; c_seen = 1;
    end
    sat_c = 1; rdy_c = 1; seed_c = 16'hACE1; seed_we_c = 1; start_c = 1;
    @(negedge clk); start_c = 0; seed_we_c = 0;
    g_n = 0; g_em = '0;
    for (int k = 0; k < 400 && !done_c && !fail_c; k++) begin
      if (sol_vld_c) begin
        if (g_n < 4) g_em[g_n] = sol_c[0];
        g_n++;
      end
      @(negedge clk);
    end
    chk("t6_nsol", 128'(g_n), 128'(m_s));
    chk("t6_bits", {124'b0, g_em}, {124'b0, m_em});
    chk("t6_tries", {123'b0, tries_c}, 128'(m_t));
    chk("t6_flags", {126'b0, done_c, fail_c}, {126'b0, !m_fail, m_fail});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
